shift_div16: RTL
================

SHIFT_DIV16 -- requirements
Module: shift_div16

Interface
REQ-001 SHALL have parameter B_WIDTH, default 8, giving the divisor and remainder width (1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the falling edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a division.
REQ-005 SHALL have port a  input  16  unsigned dividend.
REQ-006 SHALL have port b  input  B_WIDTH  unsigned divisor.
REQ-007 SHALL have port busy  output  1  division in progress.
REQ-008 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port q  output  16  quotient.
REQ-010 SHALL have port r  output  B_WIDTH  remainder.
REQ-011 SHALL have port div_zero  output  1  divisor-zero flag for the last result.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, sampling it at the falling edge E0 where a and b are latched, the partial remainder is cleared, the iteration counter is set to 16, and the state becomes RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on the latched operands or the result.
REQ-015 SHALL perform restoring division in RUN, one quotient bit per edge, MSB first: rem' = {rem, next dividend bit}; if rem' >= b (b zero-extended) then rem' -= b and the quotient bit is 1, else the quotient bit is 0.
REQ-016 SHALL hold the partial remainder internally in B_WIDTH+1 bits so the compare never overflows.
REQ-017 SHALL complete the 16th iteration at edge E16, entering DONE with done=1 and busy=0, so latency is 16 edges from acceptance to done.
REQ-018 SHALL return from DONE to IDLE at the next edge, or to RUN if start is sampled there.
REQ-019 SHALL drive busy=1 exactly while in RUN.
REQ-020 SHALL update q and r only on entry to DONE and hold them until the next DONE entry or reset.
REQ-021 SHALL guarantee, for every nonzero b, that a == q*b + r and r < b.

Reset
REQ-022 SHALL, while rst_n=0, immediately force state=IDLE and busy=0, done=0, q=0, r=0, div_zero=0, and clear all internal registers.
REQ-023 SHALL treat reset asserted mid-RUN as an abort: no done pulse, no partial result visible, and a new start accepted normally after release.

Configuration
REQ-024 SHALL, with macro SHIFT_DIV_ZERO_CHECK_EN defined, detect b==0 at acceptance and enter DONE at E1 (latency 1) with q=16'hFFFF, r=a[B_WIDTH-1:0] and div_zero=1; div_zero SHALL be 0 for every nonzero-divisor result.
REQ-025 SHALL, without SHIFT_DIV_ZERO_CHECK_EN, tie div_zero to 0 and run b==0 through the normal 16 iterations, naturally yielding q=16'hFFFF and r=a[B_WIDTH-1:0] at E16.

Verification
REQ-026 SHALL cover a=1000, b=7 -> done at E16, q=142, r=6, busy high E0..E15 and low at E16.
REQ-027 SHALL cover a=16'hFFFF, b=255 -> q=257, r=0; and a=5, b=9 -> q=0, r=5.
REQ-028 SHALL cover a=16'h1234, b=0 -> q=16'hFFFF and r=8'h34; with the macro, div_zero=1 and done at E1; without it, div_zero=0 and done at E16.
REQ-029 SHALL cover start pulsed again at E5 with a=3, b=1 during a 1000/7 run -> ignored, result still q=142, r=6.
REQ-030 SHALL cover rst_n low at E8 of a 1000/7 run -> all outputs 0 immediately and no done pulse; then 200/3 after release -> q=66, r=2.
REQ-031 SHALL cover start held high through DONE for back-to-back 100/10 and 99/10 -> q=10, r=0, then q=9, r=9, with no idle cycle between runs.

Source files
------------

// File: rtl/shift_div16.sv
// Sequential restoring divider: 16-bit dividend, B_WIDTH divisor, one bit per falling edge.
// Define SHIFT_DIV_ZERO_CHECK_EN for a one-edge divide-by-zero shortcut with div_zero flag.
module shift_div16 #(
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        a,
    input  logic [B_WIDTH-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [15:0]        q,
    output logic [B_WIDTH-1:0] r,
    output logic               div_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [15:0]        dvd;
    logic [B_WIDTH-1:0] dvs;
    logic [B_WIDTH:0]   rem, rem_sh, rem_nx;
    logic [4:0]         cnt;
    logic               qbit, accept, last;

    // dvd shifts the dividend out of its top while quotient bits enter at the bottom
    assign rem_sh = (rem << 1) | {{B_WIDTH{1'b0}}, dvd[15]};
    assign qbit   = rem_sh >= {1'b0, dvs};
    assign rem_nx = qbit ? rem_sh - {1'b0, dvs} : rem_sh;
    assign accept = start && (state != RUN);

`ifdef SHIFT_DIV_ZERO_CHECK_EN
    logic zero, dz_q;
    assign last     = (state == RUN) && ((cnt == 5'd1) || zero);
    assign div_zero = dz_q;
`else
    assign last     = (state == RUN) && (cnt == 5'd1);
    assign div_zero = 1'b0;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last)  state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd  <= '0;
            dvs  <= '0;
            rem  <= '0;
            cnt  <= '0;
            q    <= '0;
            r    <= '0;
`ifdef SHIFT_DIV_ZERO_CHECK_EN
            zero <= 1'b0;
            dz_q <= 1'b0;
`endif
        end else if (accept) begin
            dvd  <= a;
            dvs  <= b;
            rem  <= '0;
            cnt  <= 5'd16;
`ifdef SHIFT_DIV_ZERO_CHECK_EN
            zero <= (b == '0);
`endif
        end else if (state == RUN) begin
            dvd <= {dvd[14:0], qbit};
            rem <= rem_nx;
            cnt <= cnt - 5'd1;
            if (last) begin
                q <= {dvd[14:0], qbit};
                r <= rem_nx[B_WIDTH-1:0];
`ifdef SHIFT_DIV_ZERO_CHECK_EN
                dz_q <= zero;
                if (zero) begin
                    q <= 16'hFFFF;
                    r <= dvd[B_WIDTH-1:0];
                end
`endif
            end
        end
    end

endmodule
